// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes and the 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PA_DR  = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PA_IR  = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_t;

  localparam logic [3:0] OP_EXTEST  = 4'b0000;
  localparam logic [3:0] OP_SAMPLE  = 4'b0001;
  localparam logic [3:0] OP_IDCODE  = 4'b0010;
  localparam logic [3:0] OP_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PA_DR;
      PA_DR:  n = tms ? EX2_DR : PA_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PA_IR;
      PA_IR:  n = tms ? EX2_IR : PA_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register; advances on rising TCK, forced to Test-Logic-Reset by TRST.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst,
  input  logic       i_tms,
  output tap_state_t o_state
);

  tap_state_t r_state;

  always_ff @(posedge i_tck or posedge i_trst) begin
    if (i_trst) r_state <= TLR;
    else        r_state <= tap_next(r_state, i_tms);
  end

  assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: IR, IDCODE/bypass registers, TDO mux and gated BSR strobes.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       tdo_en,
  output logic       bsr_tdi,
  input  logic       bsr_tdo,
  output logic       shift_dr,
  output logic       capture_dr,
  output logic       update_dr,
  output logic       mode,
  output logic [3:0] tap_state
);

  tap_state_t          w_state;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_ir_latch;
  logic [31:0]         r_idcode;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                r_shift_dr;
  logic                r_en_cap;
  logic                r_en_upd;
  logic                w_sel_bsr;
  logic                w_sel_id;
  logic                w_sel_byp;
  logic                w_dr_tdo;

  jtag_tap_fsm u_fsm (
    .i_tck   (TCK),
    .i_trst  (TRST),
    .i_tms   (TMS),
    .o_state (w_state)
  );

  // Unrecognised opcodes fall through to bypass.
  assign w_sel_bsr = (r_ir_latch == OP_EXTEST) || (r_ir_latch == OP_SAMPLE);
  assign w_sel_id  = (r_ir_latch == OP_IDCODE);
  assign w_sel_byp = !w_sel_bsr && !w_sel_id;
  assign w_dr_tdo  = w_sel_bsr ? bsr_tdo : (w_sel_id ? r_idcode[0] : r_bypass);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_ir_shift <= IR_CAPTURE;
      r_bypass   <= 1'b0;
      r_idcode   <= IDCODE_VAL;
    end else begin
      case (w_state)
        TLR: begin
          r_ir_shift <= IR_CAPTURE;
          r_bypass   <= 1'b0;
          r_idcode   <= IDCODE_VAL;
        end
        CAP_IR: r_ir_shift <= IR_CAPTURE;
        SH_IR:  r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
        CAP_DR: begin
          if (w_sel_id)  r_idcode <= IDCODE_VAL;
          if (w_sel_byp) r_bypass <= 1'b0;
        end
        SH_DR: begin
          if (w_sel_id)  r_idcode <= {TDI, r_idcode[31:1]};
          if (w_sel_byp) r_bypass <= TDI;
        end
        default: ;
      endcase
    end
  end

  // Everything that feeds a pin or a strobe enable changes only while TCK is low.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      r_ir_latch <= OP_IDCODE;
      r_tdo      <= 1'b0;
      r_tdo_en   <= 1'b0;
      r_shift_dr <= 1'b0;
      r_en_cap   <= 1'b0;
      r_en_upd   <= 1'b0;
    end else begin
      if (w_state == TLR)         r_ir_latch <= OP_IDCODE;
      else if (w_state == UPD_IR) r_ir_latch <= r_ir_shift;
      r_tdo_en   <= (w_state == SH_DR) || (w_state == SH_IR);
      r_tdo      <= (w_state == SH_IR) ? r_ir_shift[0] :
                    (w_state == SH_DR) ? w_dr_tdo : 1'b0;
      r_shift_dr <= (w_state == SH_DR);
      r_en_cap   <= w_sel_bsr && ((w_state == CAP_DR) || (w_state == SH_DR));
      r_en_upd   <= w_sel_bsr && (w_state == UPD_DR);
    end
  end

  assign TDO        = r_tdo;
  assign tdo_en     = r_tdo_en;
  assign bsr_tdi    = TDI;
  assign shift_dr   = r_shift_dr;
  assign capture_dr = TCK & r_en_cap;
  assign update_dr  = TCK & r_en_upd;
  assign mode       = (r_ir_latch == OP_EXTEST);
  assign tap_state  = w_state;

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1-style TAP controller driving the boundary-scan chain of `bsr_out`/input cells. It decodes TMS into the 16-state TAP state machine and holds a 4-bit instruction register. It also holds the bypass and IDCODE data registers. It generates the `shift_dr`, `capture_dr`, `update_dr` and `mode` controls consumed by every BSR cell, and it muxes the selected register onto TDO. It sits between the chip-level JTAG pins and the head/tail of the BSR chain.

## Interface
- `IR_WIDTH`, 4: instruction register width.
- `IDCODE_VAL`, 32'h1000_0001: value captured into the IDCODE register; bit 0 is always 1.
- `BSR_LEN`, 8: number of cells in the chain; used by the bench only.

Ports:
- `TCK` in 1: the single clock. Rising edge samples TMS/TDI and advances the state. Falling edge updates outputs.
- `TRST` in 1: reset. It is asynchronous and active-high.
- `TMS` in 1: test mode select.
- `TDI` in 1: test data in.
- `TDO` out 1: test data out.
- `tdo_en` out 1: TDO drive enable.
- `bsr_tdi` out 1: serial data to the first BSR cell `scan_in`.
- `bsr_tdo` in 1: `scan_out` of the last BSR cell.
- `shift_dr` out 1: level that selects serial shift in BSR cells.
- `capture_dr` out 1: gated strobe that clocks the BSR capture flops.
- `update_dr` out 1: gated strobe that clocks the BSR update flops.
- `mode` out 1: drives BSR cell `mode`; 1 connects the update flop to the pad.
- `tap_state` out 4: current TAP state, for debug.

## Operation
- **FSM states:** TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the IR equivalents. Transitions follow standard 1149.1 on TMS at rising TCK.
- **Any-state reset:** five consecutive TMS=1 reach TLR from any state.
- **Instructions:** EXTEST=4'b0000, SAMPLE=4'b0001, IDCODE=4'b0010, BYPASS=4'b1111. Any other opcode behaves as BYPASS.
- **IR shift register:**
  - CAP_IR loads 4'b0001.
  - SH_IR shifts LSB-first from TDI; the LSB goes to TDO.
  - The IR latch loads on falling TCK in UPD_IR.
  - TLR forces the latch to IDCODE.
- **DR selection by instruction:**
  - EXTEST/SAMPLE: BSR chain. `bsr_tdi`=TDI; TDO source is `bsr_tdo`.
  - IDCODE: 32-bit shift register. Loads `IDCODE_VAL` in CAP_DR and shifts LSB-first.
  - BYPASS: 1-bit register. Captures 0 and shifts TDI through.
- **BSR strobes** are active only when EXTEST or SAMPLE is selected.
  - `capture_dr` pulses in CAP_DR and in each SH_DR cycle, so the capture flop both captures and shifts.
  - `update_dr` pulses in UPD_DR.
  - `shift_dr` is high during SH_DR.
- **mode:** `mode`=1 iff the latched IR is EXTEST.
- **TDO and tdo_en:** `tdo_en`=1 only in SH_DR/SH_IR. When `tdo_en`=0, TDO=0.

## Timing
- **Rising TCK:**
  - TMS and TDI are sampled.
  - The state register updates.
  - The IR, IDCODE and bypass shift registers update.
- **Falling TCK:**
  - `shift_dr`, the strobe-enable flops, the IR latch, `TDO` and `tdo_en` update.
- **Strobe generation:**
  - `capture_dr` = TCK AND en_cap, where en_cap is registered on falling TCK.
  - `update_dr` = TCK AND en_upd, built the same way.
  - The strobes are glitch-free because the enables change only while TCK is low.
  - Each strobe's rising edge is the rising TCK that ends the CAP_DR/SH_DR/UPD_DR cycle.
- **Reset values:** state=TLR, IR latch=IDCODE, IR shift=4'b0001, bypass=0, IDCODE shift=`IDCODE_VAL`. All outputs are 0 (`TDO`, `tdo_en`, `shift_dr`, strobes, `mode`).
- **Reset mid-shift:** asserting TRST aborts immediately. No update strobe is issued and `mode` drops to 0 asynchronously.
- **TLR without TRST:** reached via TMS. It forces the same register values on the next falling TCK.
- **Pause states:** PA_DR/PA_IR hold all shift contents. No strobes fire.
- **Empty update:** UPD_DR with a non-BSR instruction selected produces no `update_dr` pulse.

## Structure
- **Package `jtag_pkg`:**
  - `tap_state_t` enum, 4-bit encoding.
  - Opcode localparams.
  - `IR_CAPTURE` constant.
  - A `tap_next()` function.
- **Sub-module `jtag_tap_fsm`:** the state register plus next-state logic, with `tap_state` as output.
- **Top:** holds the IR, data registers, TDO mux and strobe generation.

## Test plan
- **Reset:** assert TRST, then release → `tap_state`=TLR, `mode`=0, `tdo_en`=0.
- **TLR recovery:** from SH_DR, drive TMS=1 for 5 TCKs → TLR. IR latch reads IDCODE and no `update_dr` pulse occurs.
- **IDCODE read:** after reset, TMS sequence 0,1,0,0 reaches SH_DR. Shift 32 bits → TDO yields 32'h1000_0001 LSB-first.
- **BYPASS:** load IR=4'b1111, then shift pattern 1011 through DR → TDO shows 0 followed by 1011, delayed one TCK. The captured IR read out during SH_IR is 0001.
- **EXTEST:** load IR=4'b0000 → `mode`=1.
  - Shift 8 bits: exactly 9 `capture_dr` pulses (1 capture + 8 shifts) with `shift_dr`=1 during the 8.
  - Then UPD_DR: exactly 1 `update_dr` pulse.
- **Reset mid-shift:** EXTEST, TRST asserted at the 3rd SH_DR cycle → `mode` drops to 0 immediately, no `update_dr`, state=TLR.
